// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one downstream memory bus between the instruction fetch port
//   (read-only) and the load/store port (read/write with byte selects).
//   Each port captures single-cycle request pulses into a one-deep pending
//   register. The arbiter grants one port at a time, runs one req/ack
//   transaction downstream and returns data with a one-cycle ack pulse.
//   Transactions that receive no ack within TIMEOUT grant cycles are aborted
//   and completed with an error.
//
// Optional feature:
//   MEM_ARB_RR_EN  defined   -> round-robin between the two ports
//                  undefined -> fixed priority, LSU over fetch
//
// Ports:
//   i_clk, i_rst, i_clk_en        clock, async active-high reset, clock enable
//   i_f_read, i_f_addr            fetch request pulse and address
//   o_f_data, o_f_ack, o_f_err    fetch read data, completion pulse, timeout error
//   i_l_read, i_l_write           load / store request pulses
//   i_l_addr, i_l_wdata, i_l_sel  load/store address, store data, byte selects
//   o_l_data, o_l_ack, o_l_err    load data, completion pulse, timeout error
//   o_m_req, o_m_we, o_m_addr,    downstream request (held until ack/abort),
//   o_m_wdata, o_m_sel            write enable, address, write data, selects
//   i_m_data, i_m_ack             downstream read data and ack

module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    input  logic              i_f_read,
    input  logic [AW-1:0]     i_f_addr,
    output logic [DW-1:0]     o_f_data,
    output logic              o_f_ack,
    output logic              o_f_err,
    input  logic              i_l_read,
    input  logic              i_l_write,
    input  logic [AW-1:0]     i_l_addr,
    input  logic [DW-1:0]     i_l_wdata,
    input  logic [DW/8-1:0]   i_l_sel,
    output logic [DW-1:0]     o_l_data,
    output logic              o_l_ack,
    output logic              o_l_err,
    output logic              o_m_req,
    output logic              o_m_we,
    output logic [AW-1:0]     o_m_addr,
    output logic [DW-1:0]     o_m_wdata,
    output logic [DW/8-1:0]   o_m_sel,
    input  logic [DW-1:0]     i_m_data,
    input  logic              i_m_ack
);

    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_F,
        GRANT_L
    } state_t;

    state_t          state_q;

    // One-deep pending registers
    logic            f_pend_q;
    logic [AW-1:0]   f_addr_q;
    logic            l_pend_q;
    logic            l_we_q;
    logic [AW-1:0]   l_addr_q;
    logic [DW-1:0]   l_wdata_q;
    logic [SW-1:0]   l_sel_q;

    logic [CW-1:0]   tmo_q;

    // Registered outputs
    logic            m_req_q;
    logic            m_we_q;
    logic [AW-1:0]   m_addr_q;
    logic [DW-1:0]   m_wdata_q;
    logic [SW-1:0]   m_sel_q;
    logic [DW-1:0]   f_data_q;
    logic            f_ack_q;
    logic            f_err_q;
    logic [DW-1:0]   l_data_q;
    logic            l_ack_q;
    logic            l_err_q;

    logic            pick_l_d;
    logic            tmo_hit;

`ifdef MEM_ARB_RR_EN
    logic            last_l_q;   // 1: the LSU port won the most recent grant

    always_comb begin
        pick_l_d = l_pend_q;
        if (l_pend_q && f_pend_q) begin
            pick_l_d = !last_l_q;
        end
    end
`else
    always_comb begin
        pick_l_d = l_pend_q;
    end
`endif

    // TIMEOUT == 0 disables the abort path entirely.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            f_pend_q  <= 1'b0;
            f_addr_q  <= '0;
            l_pend_q  <= 1'b0;
            l_we_q    <= 1'b0;
            l_addr_q  <= '0;
            l_wdata_q <= '0;
            l_sel_q   <= '0;
            tmo_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_sel_q   <= '0;
            f_data_q  <= '0;
            f_ack_q   <= 1'b0;
            f_err_q   <= 1'b0;
            l_data_q  <= '0;
            l_ack_q   <= 1'b0;
            l_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_l_q  <= 1'b1;
`endif
        end else if (i_clk_en) begin
            f_ack_q <= 1'b0;
            f_err_q <= 1'b0;
            l_ack_q <= 1'b0;
            l_err_q <= 1'b0;

            // Capture only into an empty slot; the flag stays set until the
            // transaction completes, so pulses while in service are dropped.
            if (i_f_read && !f_pend_q) begin
                f_pend_q <= 1'b1;
                f_addr_q <= i_f_addr;
            end
            if ((i_l_read || i_l_write) && !l_pend_q) begin
                l_pend_q  <= 1'b1;
                l_we_q    <= i_l_write;
                l_addr_q  <= i_l_addr;
                l_wdata_q <= i_l_wdata;
                l_sel_q   <= i_l_sel;
            end

            case (state_q)
                IDLE: begin
                    m_req_q <= 1'b0;
                    tmo_q   <= '0;
                    if (f_pend_q || l_pend_q) begin
                        m_req_q <= 1'b1;
                        if (pick_l_d) begin
                            m_we_q    <= l_we_q;
                            m_addr_q  <= l_addr_q;
                            m_wdata_q <= l_wdata_q;
                            m_sel_q   <= l_sel_q;
                            state_q   <= GRANT_L;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_addr_q  <= f_addr_q;
                            m_wdata_q <= '0;
                            m_sel_q   <= '1;
                            state_q   <= GRANT_F;
                        end
`ifdef MEM_ARB_RR_EN
                        last_l_q <= pick_l_d;
`endif
                    end
                end

                GRANT_F, GRANT_L: begin
                    // An ack on the timeout edge completes normally.
                    if (i_m_ack || tmo_hit) begin
                        m_req_q <= 1'b0;
                        state_q <= IDLE;
                        if (state_q == GRANT_F) begin
                            f_ack_q  <= 1'b1;
                            f_err_q  <= !i_m_ack;
                            f_data_q <= i_m_ack ? i_m_data : '0;
                            f_pend_q <= 1'b0;
                        end else begin
                            l_ack_q  <= 1'b1;
                            l_err_q  <= !i_m_ack;
                            l_data_q <= (i_m_ack && !m_we_q) ? i_m_data : '0;
                            l_pend_q <= 1'b0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_m_req   = m_req_q;
    assign o_m_we    = m_we_q;
    assign o_m_addr  = m_addr_q;
    assign o_m_wdata = m_wdata_q;
    assign o_m_sel   = m_sel_q;
    assign o_f_data  = f_data_q;
    assign o_f_ack   = f_ack_q;
    assign o_f_err   = f_err_q;
    assign o_l_data  = l_data_q;
    assign o_l_ack   = l_ack_q;
    assign o_l_err   = l_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter (AW=DW=32, TIMEOUT=16).
//   Expectations follow the round-robin rule when MEM_ARB_RR_EN is defined,
//   fixed LSU>fetch priority otherwise.

module tb_mem_bus_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_clk_en;
    logic            i_f_read;
    logic [AW-1:0]   i_f_addr;
    logic [DW-1:0]   o_f_data;
    logic            o_f_ack;
    logic            o_f_err;
    logic            i_l_read;
    logic            i_l_write;
    logic [AW-1:0]   i_l_addr;
    logic [DW-1:0]   i_l_wdata;
    logic [SW-1:0]   i_l_sel;
    logic [DW-1:0]   o_l_data;
    logic            o_l_ack;
    logic            o_l_err;
    logic            o_m_req;
    logic            o_m_we;
    logic [AW-1:0]   o_m_addr;
    logic [DW-1:0]   o_m_wdata;
    logic [SW-1:0]   o_m_sel;
    logic [DW-1:0]   i_m_data;
    logic            i_m_ack;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_f_read(i_f_read), .i_f_addr(i_f_addr),
        .o_f_data(o_f_data), .o_f_ack(o_f_ack), .o_f_err(o_f_err),
        .i_l_read(i_l_read), .i_l_write(i_l_write), .i_l_addr(i_l_addr),
        .i_l_wdata(i_l_wdata), .i_l_sel(i_l_sel),
        .o_l_data(o_l_data), .o_l_ack(o_l_ack), .o_l_err(o_l_err),
        .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_addr(o_m_addr),
        .o_m_wdata(o_m_wdata), .o_m_sel(o_m_sel),
        .i_m_data(i_m_data), .i_m_ack(i_m_ack)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_f_read  = 1'b0;
        i_l_read  = 1'b0;
        i_l_write = 1'b0;
        i_m_ack   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_clk_en = 1'b1;
        i_rst    = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    // Called one cycle after the granting edge: checks the bus, acks at once,
    // then checks the completion pulse on the requesting port.
    task automatic serve(input string tag, input bit lsu, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] sel, input logic [31:0] rdata);
        check({tag, "_grant"}, 80'({o_m_req, o_m_we, o_m_sel, o_m_addr}),
              80'({1'b1, we, sel, addr}));
        if (we) check({tag, "_wdata"}, 80'(o_m_wdata), 80'(wd));
        i_m_ack  = 1'b1;
        i_m_data = rdata;
        tick();
        i_m_ack  = 1'b0;
        i_m_data = $urandom;
        if (lsu)
            check({tag, "_done"}, 80'({o_m_req, o_f_ack, o_l_ack, o_l_err, o_l_data}),
                  80'({1'b0, 1'b0, 1'b1, 1'b0, (we ? 32'h0 : rdata)}));
        else
            check({tag, "_done"}, 80'({o_m_req, o_f_ack, o_l_ack, o_f_err, o_f_data}),
                  80'({1'b0, 1'b1, 1'b0, 1'b0, rdata}));
    endtask

    task automatic lone_read(input string tag, input bit lsu, input logic [31:0] addr,
                             input logic [31:0] rdata);
        if (lsu) begin
            i_l_read = 1'b1; i_l_addr = addr; i_l_sel = 4'hF;
        end else begin
            i_f_read = 1'b1; i_f_addr = addr;
        end
        tick();
        idle_inputs();
        check({tag, "_lat"}, 80'(o_m_req), 80'(0));
        tick();
        serve(tag, lsu, 1'b0, addr, 32'h0, 4'hF, rdata);
        tick();
    endtask

    task automatic both_req(input string tag, input bit first_lsu);
        i_f_read  = 1'b1; i_f_addr  = 32'h200;
        i_l_write = 1'b1; i_l_addr  = 32'h1000;
        i_l_wdata = 32'hDEADBEEF; i_l_sel = 4'h3;
        tick();
        idle_inputs();
        check({tag, "_lat"}, 80'(o_m_req), 80'(0));
        tick();
        if (first_lsu) begin
            serve({tag, "_l"}, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'h3, 32'h5555);
            tick();  // mandatory idle cycle, next edge grants fetch
            serve({tag, "_f"}, 1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 32'h13);
        end else begin
            serve({tag, "_f"}, 1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 32'h13);
            tick();
            serve({tag, "_l"}, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'h3, 32'h5555);
        end
        tick();
    endtask

    typedef struct {
        bit          lsu;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          delay;     // grant cycles before the slave acks
        logic [31:0] rdata;
        bit          exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t tbl[8];
    int   kexp;

    // Random-phase reference model: transaction view of the two ports
    bit          m_pend[2];
    bit          snap[2];
    bit          m_we[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_sel[2];
    int          active;
    int          hi_cnt;
    int          last;
    int          slv_delay;
    int          w;
    bit          en, fr, lr, lw, ack;
    logic [31:0] fa, la, lwd, md;
    logic [3:0]  ls;
    bit          e_req, e_mwe, e_fack, e_ferr, e_lack, e_lerr;
    logic [31:0] e_maddr, e_mwdata, e_fdata, e_ldata;
    logic [3:0]  e_msel;

    function automatic int pick(input bit pf, input bit pl, input int lst);
        if (RR && pf && pl) return (lst == 1) ? 0 : 1;
        return pl ? 1 : 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_clk_en = 1'b1;
        i_f_addr = '0; i_l_addr = '0; i_l_wdata = '0; i_l_sel = '0; i_m_data = '0;
        idle_inputs();

        tbl[0] = '{0, 1, 0, 32'h100,  32'h0,        4'h0, 2,  32'h13,       0, 4'hF, 32'h13,       0};
        tbl[1] = '{1, 1, 0, 32'h2000, 32'h0,        4'h5, 0,  32'hCAFEF00D, 0, 4'h5, 32'hCAFEF00D, 0};
        tbl[2] = '{1, 0, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 1,  32'h12345678, 1, 4'h3, 32'h0,        0};
        tbl[3] = '{1, 1, 1, 32'h3000, 32'h55AA,     4'hF, 3,  32'hFFFF,     1, 4'hF, 32'h0,        0};
        tbl[4] = '{1, 1, 0, 32'h40,   32'h0,        4'h1, 16, 32'hAAAA,     0, 4'h1, 32'h0,        1};
        tbl[5] = '{0, 1, 0, 32'h44,   32'h0,        4'h0, 0,  32'h0BADC0DE, 0, 4'hF, 32'h0BADC0DE, 0};
        tbl[6] = '{0, 1, 0, 32'h48,   32'h0,        4'h0, 15, 32'h77,       0, 4'hF, 32'h77,       0};
        tbl[7] = '{0, 1, 0, 32'h4C,   32'h0,        4'h0, 16, 32'h88,       0, 4'hF, 32'h0,        1};

        do_reset();
        check("reset_bus", 80'({o_m_req, o_m_we, o_m_sel, o_m_addr, o_m_wdata}), 80'(0));
        check("reset_resp", 80'({o_f_ack, o_f_err, o_f_data, o_l_ack, o_l_err, o_l_data}), 80'(0));

        for (int n = 0; n < 8; n++) begin
            vec_t v;
            v = tbl[n];
            if (v.lsu) begin
                i_l_read = v.rd; i_l_write = v.wr; i_l_addr = v.addr;
                i_l_wdata = v.wdata; i_l_sel = v.sel;
            end else begin
                i_f_read = 1'b1; i_f_addr = v.addr;
            end
            tick();
            idle_inputs();
            check("tbl_lat", 80'(o_m_req), 80'(0));
            tick();
            check("tbl_grant", 80'({o_m_req, o_m_we, o_m_sel, o_m_addr}),
                  80'({1'b1, v.exp_we, v.exp_sel, v.addr}));
            if (v.exp_we) check("tbl_wdata", 80'(o_m_wdata), 80'(v.wdata));
            kexp = (v.delay < TIMEOUT) ? v.delay : TIMEOUT - 1;
            for (int k = 0; k <= kexp; k++) begin
                i_m_ack  = (k == v.delay);
                i_m_data = (k == v.delay) ? v.rdata : $urandom;
                tick();
                i_m_ack = 1'b0;
                if (k < kexp)
                    check("tbl_hold", 80'({o_m_req, o_m_addr, o_f_ack, o_l_ack}),
                          80'({1'b1, v.addr, 1'b0, 1'b0}));
            end
            if (v.lsu)
                check("tbl_done", 80'({o_m_req, o_f_ack, o_l_ack, o_l_err, o_l_data}),
                      80'({1'b0, 1'b0, 1'b1, v.exp_err, v.exp_data}));
            else
                check("tbl_done", 80'({o_m_req, o_f_ack, o_l_ack, o_f_err, o_f_data}),
                      80'({1'b0, 1'b1, 1'b0, v.exp_err, v.exp_data}));
            tick();
            check("tbl_pulse", 80'({o_m_req, o_f_ack, o_l_ack, o_f_err, o_l_err}), 80'(0));
        end

        // Arbitration: after reset, after an LSU grant, after a fetch grant
        do_reset();
        both_req("both_rst", !RR);
        lone_read("pre_l", 1'b1, 32'h600, 32'h600);
        both_req("both_after_l", !RR);
        lone_read("pre_f", 1'b0, 32'h700, 32'h700);
        both_req("both_after_f", 1'b1);

        // Reset while a grant is outstanding
        i_f_read = 1'b1; i_f_addr = 32'h500;
        tick();
        idle_inputs();
        tick();
        check("rst_pre", 80'(o_m_req), 80'(1));
        #2 i_rst = 1'b1;
        #1;
        check("rst_async", 80'({o_m_req, o_f_ack, o_l_ack, o_f_err, o_l_err}), 80'(0));
        #1 i_rst = 1'b0;
        tick();
        tick();
        check("rst_discard", 80'({o_m_req, o_f_ack}), 80'(0));
        lone_read("rst_after", 1'b0, 32'h8, 32'h1234);

        // Clock-enable freeze with ack held high
        i_l_read = 1'b1; i_l_addr = 32'h60; i_l_sel = 4'hF;
        tick();
        idle_inputs();
        tick();
        check("ce_grant", 80'({o_m_req, o_m_addr}), 80'({1'b1, 32'h60}));
        i_m_ack = 1'b1; i_m_data = 32'h99; i_clk_en = 1'b0;
        repeat (5) begin
            tick();
            check("ce_frozen", 80'({o_m_req, o_l_ack, o_m_addr}), 80'({1'b1, 1'b0, 32'h60}));
        end
        i_clk_en = 1'b1;
        tick();
        i_m_ack = 1'b0;
        check("ce_done", 80'({o_m_req, o_l_ack, o_l_err, o_l_data}), 80'({1'b0, 1'b1, 1'b0, 32'h99}));
        i_clk_en = 1'b0;
        tick();
        tick();
        check("ce_hold_ack", 80'({o_l_ack, o_l_data}), 80'({1'b1, 32'h99}));
        i_clk_en = 1'b1;
        tick();
        check("ce_pulse", 80'(o_l_ack), 80'(0));

        // Randomized traffic against the transaction-level model
        do_reset();
        m_pend = '{0, 0}; active = -1; hi_cnt = 0; last = 1; slv_delay = 0;
        e_req = 0; e_mwe = 0; e_msel = '0; e_maddr = '0; e_mwdata = '0;
        e_fack = 0; e_ferr = 0; e_fdata = '0; e_lack = 0; e_lerr = 0; e_ldata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en  = ($urandom_range(0, 9) != 0);
            fr  = ($urandom_range(0, 4) == 0);
            lr  = ($urandom_range(0, 6) == 0);
            lw  = ($urandom_range(0, 6) == 0);
            fa  = $urandom; la = $urandom; lwd = $urandom; md = $urandom;
            ls  = 4'($urandom);
            ack = (active >= 0) ? (hi_cnt == slv_delay) : ($urandom_range(0, 7) == 0);
            i_clk_en = en; i_f_read = fr; i_f_addr = fa;
            i_l_read = lr; i_l_write = lw; i_l_addr = la; i_l_wdata = lwd; i_l_sel = ls;
            i_m_ack = ack; i_m_data = md;
            tick();
            if (en) begin
                snap = m_pend;
                e_fack = 0; e_ferr = 0; e_lack = 0; e_lerr = 0;
                if (active < 0) begin
                    e_req = 0;
                    if (snap[0] || snap[1]) begin
                        w = pick(snap[0], snap[1], last);
                        active = w; last = w; hi_cnt = 0; e_req = 1;
                        slv_delay = $urandom_range(0, TIMEOUT + 2);
                        e_maddr = m_addr[w];
                        e_mwe   = (w == 1) ? m_we[1] : 1'b0;
                        e_msel  = (w == 1) ? m_sel[1] : 4'hF;
                        e_mwdata = m_wdata[1];
                    end
                end else begin
                    hi_cnt++;
                    if (ack || hi_cnt == TIMEOUT) begin
                        if (active == 0) begin
                            e_fack = 1; e_ferr = !ack; e_fdata = ack ? md : 32'h0;
                        end else begin
                            e_lack = 1; e_lerr = !ack; e_ldata = (ack && !e_mwe) ? md : 32'h0;
                        end
                        m_pend[active] = 0;
                        active = -1;
                        e_req = 0;
                    end
                end
                if (fr && !snap[0]) begin
                    m_pend[0] = 1; m_addr[0] = fa;
                end
                if ((lr || lw) && !snap[1]) begin
                    m_pend[1] = 1; m_addr[1] = la; m_we[1] = lw; m_wdata[1] = lwd; m_sel[1] = ls;
                end
            end
            check("rand_bus", 80'({o_m_req, o_m_we, o_m_sel, o_m_addr, (e_mwe ? o_m_wdata : 32'h0)}),
                  80'({e_req, e_mwe, e_msel, e_maddr, (e_mwe ? e_mwdata : 32'h0)}));
            check("rand_resp", 80'({o_f_ack, o_f_err, o_f_data, o_l_ack, o_l_err, o_l_data}),
                  80'({e_fack, e_ferr, e_fdata, e_lack, e_lerr, e_ldata}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory bus between the instruction fetch port (read-only) and the load/store port (read/write with byte selects).
- Captures single-cycle request pulses, grants one requester at a time and drives one downstream req/ack transaction.
- Routes the read data and a one-cycle ack back to the granted requester.
- Aborts hung transactions with an error after a programmable timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- TIMEOUT, 16, cycles in grant without i_m_ack before abort; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_clk_en  in  1  global clock enable; when low all state is frozen.
- i_f_read  in  1  fetch read request pulse.
- i_f_addr  in  AW  fetch address, sampled with i_f_read.
- o_f_data  out  DW  fetch read data.
- o_f_ack  out  1  fetch completion pulse.
- o_f_err  out  1  fetch timeout error, valid with o_f_ack.
- i_l_read  in  1  load request pulse.
- i_l_write  in  1  store request pulse.
- i_l_addr  in  AW  load/store address.
- i_l_wdata  in  DW  store data.
- i_l_sel  in  DW/8  byte selects.
- o_l_data  out  DW  load data.
- o_l_ack  out  1  load/store completion pulse.
- o_l_err  out  1  load/store timeout error, valid with o_l_ack.
- o_m_req  out  1  downstream request, held high until ack or abort.
- o_m_we  out  1  downstream write enable.
- o_m_addr  out  AW  downstream address.
- o_m_wdata  out  DW  downstream write data.
- o_m_sel  out  DW/8  downstream byte selects; all ones for fetch.
- i_m_data  in  DW  downstream read data.
- i_m_ack  in  1  downstream ack.

Behaviour:
- Clock enable: all registers update only on a rising i_clk edge with i_clk_en=1. With i_clk_en=0, every register and output holds.
- Reset: asynchronous. State goes to IDLE; all outputs, pending flags and latched fields go to 0; the RR pointer points at fetch.
- Reset mid-transaction: o_m_req drops immediately and the transaction is discarded without an ack.
- Pending capture: each port has a one-deep pending register (flag, addr, we, wdata, sel). A request pulse sets the flag and latches the fields at that edge.
  - A pulse while that port is pending or in service is ignored; requesters must wait for ack.
  - i_l_read and i_l_write together: treated as a write.
- FSM: IDLE, GRANT_F, GRANT_L.
  - IDLE with any pending: select a winner and load o_m_* from its pending register. o_m_req goes high after that edge; go to GRANT_x.
  - Fixed priority: LSU over fetch.
  - IDLE with nothing pending: outputs o_m_req=0; o_m_* fields hold.
  - GRANT_x with i_m_ack=1 at an edge: o_x_data<=i_m_data, o_x_ack<=1, o_x_err<=0; clear the pending flag; o_m_req<=0; go to IDLE.
  - For writes o_x_data is 0.
  - o_x_ack and o_x_err are single-cycle pulses (one enabled cycle).
- Turnaround: there is always at least one IDLE cycle between transactions.
- Latency: request pulse sampled at edge 0 -> o_m_req high after edge 1 -> a combinational ack sampled at edge 2 -> o_x_ack high after edge 2.
- Spurious ack: i_m_ack in IDLE is ignored.
- Timeout counter: clog2(TIMEOUT+1) bits, cleared on entry to GRANT and incremented each enabled grant cycle.
  - If it reaches TIMEOUT-1 with no ack: o_m_req<=0, o_x_ack<=1, o_x_err<=1, o_x_data<=0; clear the pending flag; go to IDLE.
  - An ack on the same edge as the timeout wins: normal completion, no error.
- Mid-transaction stability: o_m_addr, o_m_we, o_m_wdata and o_m_sel are stable for the whole time o_m_req is high.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A one-bit last-grant register updates on every grant. When both ports are pending in IDLE, the port not granted last wins. Reset value "last=LSU", so fetch wins first.
- Undefined: fixed LSU>fetch priority; the last-grant register is not built.

Test Plan:
- Fetch only: i_f_read pulse with i_f_addr=0x100; slave acks 2 cycles after o_m_req with 0x00000013 -> o_m_addr=0x100, o_m_we=0, o_m_sel=0xF; o_f_data=0x13; o_f_ack high exactly 1 cycle; o_f_err=0.
- Simultaneous requests: fetch 0x200 and LSU write 0x1000/0xDEADBEEF/sel 0x3 on the same edge (fixed priority) -> first transaction is we=1, addr 0x1000, wdata 0xDEADBEEF, sel 0x3 with o_l_ack; then one IDLE cycle; then fetch 0x200 with o_f_ack.
- Round-robin with MEM_ARB_RR_EN: both ports pending while IDLE after an LSU grant -> fetch granted first. Same stimulus without the macro -> LSU granted first.
- Timeout: TIMEOUT=16, LSU read 0x40, slave never acks -> o_m_req high 16 cycles then low; o_l_ack=1, o_l_err=1, o_l_data=0 for 1 cycle. Then a fetch completes normally.
- Reset mid-grant: assert i_rst while o_m_req=1 -> o_m_req and all acks go 0 without a clock edge; after release a new fetch to 0x8 completes with latency 2.
- Clock-enable freeze: hold i_clk_en=0 for 5 cycles during a grant while i_m_ack=1 -> no state change, o_m_req stays 1; on the first enabled edge the ack completes.
